riscv_multicycle_controller: RTL

RISCV_MULTICYCLE_CONTROLLER -- requirements
Module: riscv_multicycle_controller

---
 rtl/riscv_ctrl_pkg.sv | 77 +++++++
 rtl/riscv_multicycle_controller_alu_decoder.sv | 31 +++
 rtl/riscv_multicycle_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared state, opcode, ALU and mux-select encodings for the
//               multicycle RISC-V controller.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b110;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;

    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_MEM    = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;
    localparam logic [1:0] c_RES_IMM    = 2'b11;

    // Branch condition from the SUB flags: beq, bne, blt, bge; others never taken.
    function automatic logic branch_taken(input logic [2:0] func3,
                                          input logic       zero,
                                          input logic       sign);
        case (func3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return sign;
            3'b101:  return !sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_multicycle_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_alu_decoder
// Description : Combinational func3/func7 to ALU_function mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       func7_b5,
    input  logic       is_rtype,
    output logic [2:0] alu_function
);

    always_comb begin
        alu_function = c_ALU_ADD;
        case (func3)
            // func7[5] is immediate data for I-type, so SUB only applies to R-type
            3'b000:  alu_function = (is_rtype && func7_b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b111:  alu_function = c_ALU_AND;
            3'b110:  alu_function = c_ALU_OR;
            3'b100:  alu_function = c_ALU_XOR;
            3'b010:  alu_function = c_ALU_SLT;
            3'b011:  alu_function = c_ALU_SLTU;
            default: alu_function = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : riscv_multicycle_controller
// Description : Moore FSM sequencing fetch/decode/execute for a multicycle
//               RV32I subset datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       SIGN,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] resultSrc,
    output logic [2:0] immSrc,
    output logic [2:0] ALU_function,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_dec_function;
    logic       w_unused_func7;

    assign w_unused_func7 = ^{func7[6], func7[4:0]};

    riscv_alu_decoder u_alu_decoder (
        .func3        (func3),
        .func7_b5     (func7[5]),
        .is_rtype     (r_state == S_EXECR),
        .alu_function (w_dec_function)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
                    c_OP_RTYPE:            w_next = S_EXECR;
                    c_OP_ITYPE:            w_next = S_EXECI;
                    c_OP_BRANCH:           w_next = S_BRANCH;
                    c_OP_JAL:              w_next = S_JAL;
                    c_OP_JALR:             w_next = S_JALR1;
                    c_OP_LUI:              w_next = S_LUI;
                    default:               w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (op == c_OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALR2: w_next = S_ALUWB;
            S_JALR1:  w_next = S_JALR2;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        adrSrc       = 1'b0;
        memWrite     = 1'b0;
        regWrite     = 1'b0;
        ALUSrcA      = c_SRCA_PC;
        ALUSrcB      = c_SRCB_RS2;
        resultSrc    = c_RES_ALUOUT;
        immSrc       = c_IMM_I;
        ALU_function = c_ALU_ADD;
        instr_done   = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                resultSrc = c_RES_ALU;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                // Precompute the PC-relative target into ALUOut for branch/JAL
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                immSrc  = (op == c_OP_JAL) ? c_IMM_J : c_IMM_B;
                instr_done = !(op == c_OP_LOAD   || op == c_OP_STORE ||
                               op == c_OP_RTYPE  || op == c_OP_ITYPE ||
                               op == c_OP_BRANCH || op == c_OP_JAL   ||
                               op == c_OP_JALR   || op == c_OP_LUI);
            end
            S_MEMADR: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
                immSrc  = (op == c_OP_STORE) ? c_IMM_S : c_IMM_I;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc  = c_RES_MEM;
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc     = 1'b1;
                memWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA      = c_SRCA_RS1;
                ALUSrcB      = c_SRCB_RS2;
                ALU_function = w_dec_function;
            end
            S_EXECI: begin
                ALUSrcA      = c_SRCA_RS1;
                ALUSrcB      = c_SRCB_IMM;
                ALU_function = w_dec_function;
            end
            S_ALUWB: begin
                resultSrc  = c_RES_ALUOUT;
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = c_SRCA_RS1;
                ALUSrcB      = c_SRCB_RS2;
                ALU_function = c_ALU_SUB;
                immSrc       = c_IMM_B;
                PCWrite      = branch_taken(func3, zero, SIGN);
                instr_done   = 1'b1;
            end
            S_JAL, S_JALR2: begin
                // PC <- ALUOut (target) while the ALU forms the link value oldPC+4
                PCWrite = 1'b1;
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_FOUR;
                immSrc  = (r_state == S_JAL) ? c_IMM_J : c_IMM_I;
            end
            S_JALR1: begin
                ALUSrcA = c_SRCA_RS1;
                ALUSrcB = c_SRCB_IMM;
            end
            S_LUI: begin
                immSrc     = c_IMM_U;
                resultSrc  = c_RES_IMM;
                regWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            regWrite   = 1'b0;
            memWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
`default_nettype wire
